// File: rtl/timer_pkg.sv
// Shared definitions for the timer array: register map, CTRL field
// positions, mode encodings and the per-channel state encoding.
package timer_pkg;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_PRESET = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   localparam int unsigned CTRL_EN_BIT     = 0;
   localparam int unsigned CTRL_MODE_LSB   = 1;
   localparam int unsigned CTRL_IM_BIT     = 3;
   localparam int unsigned CTRL_PSC_LSB    = 8;
   localparam int unsigned STATUS_PEND_BIT = 0;

   localparam logic [1:0] MODE_ONESHOT  = 2'd0;
   localparam logic [1:0] MODE_PERIODIC = 2'd1;

   typedef enum logic [1:0] {
      CH_IDLE = 2'd0,
      CH_CNT  = 2'd1,
      CH_INT  = 2'd2
   } ch_state_e;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL/PRESET/COUNT/STATUS registers, prescaler,
// IDLE/CNT/INT sequencer and masked interrupt output.
module timer_channel
   import timer_pkg::*;
#(
   parameter int unsigned CNT_W = 32,
   parameter int unsigned PRE_W = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [1:0]  reg_sel,
   input  logic [31:0] din,
   output logic [31:0] rdata,
   output logic        irq
);

   ch_state_e        state_q, state_d;
   logic             en_q, en_d;
   logic [1:0]       mode_q, mode_d;
   logic             im_q, im_d;
   logic [PRE_W-1:0] psc_q, psc_d;
   logic [PRE_W-1:0] presc_q, presc_d;
   logic [CNT_W-1:0] preset_q, preset_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             pend_q, pend_d;
   logic             tick;
   logic             unused_din;

   assign tick       = (presc_q == psc_q);
   assign unused_din = ^din;

   always_comb begin
      state_d  = state_q;
      en_d     = en_q;
      mode_d   = mode_q;
      im_d     = im_q;
      psc_d    = psc_q;
      presc_d  = presc_q;
      preset_d = preset_q;
      count_d  = count_q;
      pend_d   = pend_q;

      // W1C is applied before the sequencer so a same-edge expiry re-sets PEND
      if (wr_en && reg_sel == REG_STATUS && din[STATUS_PEND_BIT])
         pend_d = 1'b0;

      case (state_q)
         CH_IDLE: begin
            if (en_q) begin
               count_d = preset_q;
               presc_d = '0;
               state_d = CH_CNT;
            end
         end
         CH_CNT: begin
            if (tick) begin
               presc_d = '0;
               if (count_q > CNT_W'(1)) begin
                  count_d = count_q - CNT_W'(1);
               end else begin
                  count_d = '0;
                  pend_d  = 1'b1;
                  state_d = CH_INT;
               end
            end else begin
               presc_d = presc_q + PRE_W'(1);
            end
         end
         CH_INT: begin
            if (mode_q == MODE_PERIODIC) begin
               count_d = preset_q;
               presc_d = '0;
               state_d = CH_CNT;
            end else begin
               en_d    = 1'b0;
               state_d = CH_IDLE;
            end
         end
         default: state_d = CH_IDLE;
      endcase

      // CPU CTRL write overrides the sequencer; EN=0 freezes COUNT and PEND
      if (wr_en && reg_sel == REG_CTRL) begin
         en_d   = din[CTRL_EN_BIT];
         mode_d = din[CTRL_MODE_LSB +: 2];
         im_d   = din[CTRL_IM_BIT];
         psc_d  = din[CTRL_PSC_LSB +: PRE_W];
         if (!din[CTRL_EN_BIT]) begin
            state_d = CH_IDLE;
            count_d = count_q;
            presc_d = presc_q;
            pend_d  = pend_q;
         end
      end

      if (wr_en && reg_sel == REG_PRESET)
         preset_d = din[CNT_W-1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= CH_IDLE;
         en_q     <= 1'b0;
         mode_q   <= '0;
         im_q     <= 1'b0;
         psc_q    <= '0;
         presc_q  <= '0;
         preset_q <= '0;
         count_q  <= '0;
         pend_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         en_q     <= en_d;
         mode_q   <= mode_d;
         im_q     <= im_d;
         psc_q    <= psc_d;
         presc_q  <= presc_d;
         preset_q <= preset_d;
         count_q  <= count_d;
         pend_q   <= pend_d;
      end
   end

   always_comb begin
      rdata = '0;
      case (reg_sel)
         REG_CTRL: begin
            rdata[CTRL_EN_BIT]            = en_q;
            rdata[CTRL_MODE_LSB +: 2]     = mode_q;
            rdata[CTRL_IM_BIT]            = im_q;
            rdata[CTRL_PSC_LSB +: PRE_W]  = psc_q;
         end
         REG_PRESET: rdata[CNT_W-1:0]       = preset_q;
         REG_COUNT:  rdata[CNT_W-1:0]       = count_q;
         default:    rdata[STATUS_PEND_BIT] = pend_q;
      endcase
   end

   assign irq = pend_q & im_q;

endmodule

// File: rtl/timer_array.sv
// Array of N_CH timer channels behind a word-addressed register port;
// top level only decodes addresses, muxes read data and ORs interrupts.
module timer_array #(
   parameter int unsigned N_CH  = 4,
   parameter int unsigned CNT_W = 32,
   parameter int unsigned PRE_W = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [7:2]      Addr,
   input  logic            WE,
   input  logic [31:0]     Din,
   output logic [31:0]     Dout,
   output logic [N_CH-1:0] IRQ,
   output logic            IRQ_any
);

   logic [3:0]  ch_sel;
   logic [1:0]  reg_sel;
   logic [31:0] rdata [N_CH];

   assign ch_sel  = Addr[7:4];
   assign reg_sel = Addr[3:2];

   generate
      for (genvar i = 0; i < N_CH; i++) begin : g_ch
         timer_channel #(
            .CNT_W(CNT_W),
            .PRE_W(PRE_W)
         ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .wr_en  (WE && (ch_sel == 4'(i))),
            .reg_sel(reg_sel),
            .din    (Din),
            .rdata  (rdata[i]),
            .irq    (IRQ[i])
         );
      end
   endgenerate

   // Channels at or above N_CH never match, so they read as zero
   always_comb begin
      Dout = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (ch_sel == 4'(i))
            Dout = rdata[i];
      end
   end

   assign IRQ_any = |IRQ;

endmodule

// File: tb/tb_timer_array.sv
// Self-checking bench for timer_array: elapsed-time reference model,
// directed scenarios with literal expectations, then random traffic.
module tb_timer_array;

   localparam int N_CH  = 2;
   localparam int CNT_W = 16;
   localparam int PRE_W = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic [7:2]      Addr;
   logic            WE;
   logic [31:0]     Din;
   logic [31:0]     Dout;
   logic [N_CH-1:0] IRQ;
   logic            IRQ_any;

   int n_pass = 0;
   int n_tot  = 0;

   // Model: a running channel is described by cycles elapsed since load
   bit m_en   [16];
   int m_mode [16];
   bit m_im   [16];
   int m_psc  [16];
   int m_pre  [16];
   bit m_pend [16];
   bit m_act  [16];
   int m_t    [16];
   int m_p    [16];
   int m_held [16];

   timer_array #(
      .N_CH (N_CH),
      .CNT_W(CNT_W),
      .PRE_W(PRE_W)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .Addr   (Addr),
      .WE     (WE),
      .Din    (Din),
      .Dout   (Dout),
      .IRQ    (IRQ),
      .IRQ_any(IRQ_any)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   function automatic void model_reset();
      for (int c = 0; c < 16; c++) begin
         m_en[c] = 0; m_mode[c] = 0; m_im[c] = 0; m_psc[c] = 0; m_pre[c] = 0;
         m_pend[c] = 0; m_act[c] = 0; m_t[c] = 0; m_p[c] = 0; m_held[c] = 0;
      end
   endfunction

   // Expiry happens max(P,1)*(PSC+1) cycles after a load
   function automatic int texp(input int c);
      int p;
      p = (m_p[c] == 0) ? 1 : m_p[c];
      return p * (m_psc[c] + 1);
   endfunction

   function automatic int cur_count(input int c);
      if (!m_act[c]) return m_held[c];
      if (m_t[c] >= texp(c)) return 0;
      return m_p[c] - m_t[c] / (m_psc[c] + 1);
   endfunction

   function automatic logic [31:0] model_read(input int c, input int r);
      logic [31:0] v;
      v = '0;
      if (c >= N_CH) return v;
      case (r)
         0: v = 32'(m_en[c]) | (32'(m_mode[c]) << 1) | (32'(m_im[c]) << 3) | (32'(m_psc[c]) << 8);
         1: v = 32'(m_pre[c]);
         2: v = 32'(cur_count(c));
         default: v = 32'(m_pend[c]);
      endcase
      return v;
   endfunction

   function automatic logic [31:0] model_irq();
      logic [31:0] v;
      v = '0;
      for (int c = 0; c < N_CH; c++) v[c] = m_pend[c] & m_im[c];
      return v;
   endfunction

   function automatic void model_step(input bit we, input int ch, input int rg, input logic [31:0] d);
      for (int c = 0; c < N_CH; c++) begin
         bit wc;
         bit set_p;
         int te;
         wc    = we && (ch == c);
         set_p = 0;
         te    = texp(c);
         if (wc && rg == 0 && !d[0]) begin
            m_held[c] = cur_count(c);
            m_act[c]  = 0;
         end else if (m_act[c]) begin
            if (m_t[c] < te) begin
               m_t[c]++;
               if (m_t[c] == te) set_p = 1;
            end else if (m_mode[c] == 1) begin
               m_t[c] = 0;
               m_p[c] = m_pre[c];
            end else begin
               m_act[c] = 0; m_held[c] = 0; m_en[c] = 0;
            end
         end else if (m_en[c]) begin
            m_act[c] = 1; m_t[c] = 0; m_p[c] = m_pre[c];
         end
         if (wc && rg == 3 && d[0]) m_pend[c] = 0;
         if (set_p) m_pend[c] = 1;
         if (wc && rg == 0) begin
            m_en[c]   = d[0];
            m_mode[c] = int'(d[2:1]);
            m_im[c]   = d[3];
            m_psc[c]  = int'(d[11:8]);
         end
         if (wc && rg == 1) m_pre[c] = int'(d[15:0]);
      end
   endfunction

   task automatic cyc(input bit we, input int ch, input int rg, input logic [31:0] d,
                      input bit lit_en, input logic [31:0] lit, input string nm);
      WE   = we;
      Addr = {4'(ch), 2'(rg)};
      Din  = d;
      @(negedge clk);
      chk("dout", Dout, model_read(ch, rg));
      chk("irq", 32'(IRQ), model_irq());
      chk("irq_any", 32'(IRQ_any), 32'(|model_irq()));
      if (lit_en) chk(nm, Dout, lit);
      @(posedge clk);
      model_step(we, ch, rg, d);
      #1;
   endtask

   task automatic wr(input int ch, input int rg, input logic [31:0] d);
      cyc(1'b1, ch, rg, d, 1'b0, '0, "");
   endtask

   task automatic rd(input int ch, input int rg, input logic [31:0] lit, input string nm);
      cyc(1'b0, ch, rg, '0, 1'b1, lit, nm);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 0, 3, '0, 1'b0, '0, "");
   endtask

   initial begin
      reset = 1'b1; WE = 1'b0; Addr = '0; Din = '0;
      model_reset();
      #2;
      chk("rst_irq", 32'(IRQ), 32'h0);
      chk("rst_irq_any", 32'(IRQ_any), 32'h0);
      @(posedge clk); @(posedge clk); #3;
      reset = 1'b0;
      rd(0, 0, 32'h0, "rst_ctrl");
      rd(0, 2, 32'h0, "rst_count");

      // One-shot, PRESET=5, PSC=0
      wr(0, 1, 32'd5);
      wr(0, 0, 32'h9);
      rd(0, 2, 32'd0, "os_cnt_e0");
      rd(0, 2, 32'd5, "os_cnt_e1");
      rd(0, 2, 32'd4, "os_cnt_e2");
      rd(0, 2, 32'd3, "os_cnt_e3");
      rd(0, 2, 32'd2, "os_cnt_e4");
      rd(0, 2, 32'd1, "os_cnt_e5");
      chk("os_irq_e6", 32'(IRQ[0]), 32'h1);
      rd(0, 3, 32'h1, "os_pend_e6");
      rd(0, 0, 32'h8, "os_ctrl_e7");
      wr(0, 3, 32'h1);

      // Periodic, PRESET=3, PSC=1: 7-cycle period
      wr(1, 1, 32'd3);
      wr(1, 0, 32'h10B);
      idle(6);
      chk("per_irq_pre", 32'(IRQ[1]), 32'h0);
      idle(1);
      chk("per_irq_first", 32'(IRQ[1]), 32'h1);
      chk("per_any_first", 32'(IRQ_any), 32'h1);
      wr(1, 3, 32'h1);
      chk("per_irq_clr", 32'(IRQ[1]), 32'h0);
      chk("per_any_clr", 32'(IRQ_any), 32'h0);
      idle(5);
      chk("per_irq_gap", 32'(IRQ[1]), 32'h0);
      idle(1);
      chk("per_irq_second", 32'(IRQ[1]), 32'h1);
      wr(1, 0, 32'h0);
      wr(1, 3, 32'h1);

      // Stop mid-count, then re-enable
      wr(0, 1, 32'd6);
      wr(0, 0, 32'h9);
      idle(4);
      wr(0, 0, 32'h8);
      rd(0, 2, 32'd3, "stop_hold_a");
      rd(0, 2, 32'd3, "stop_hold_b");
      chk("stop_no_irq", 32'(IRQ[0]), 32'h0);
      wr(0, 0, 32'h9);
      rd(0, 2, 32'd3, "reen_hold");
      rd(0, 2, 32'd6, "reen_reload");
      wr(0, 0, 32'h0);

      // W1C on the expiry edge, then mask IRQ
      wr(0, 1, 32'd2);
      wr(0, 0, 32'h9);
      idle(2);
      wr(0, 3, 32'h1);
      rd(0, 3, 32'h1, "w1c_vs_set");
      wr(0, 0, 32'h0);
      chk("masked_irq", 32'(IRQ[0]), 32'h0);
      rd(0, 3, 32'h1, "masked_pend");
      wr(0, 3, 32'h1);

      // Unimplemented channel, unused bits, truncated PRESET
      wr(3, 0, 32'h9);
      rd(3, 0, 32'h0, "ch3_ctrl");
      wr(3, 1, 32'd7);
      rd(3, 1, 32'h0, "ch3_preset");
      wr(0, 0, 32'hFFFF_FFF0);
      rd(0, 0, 32'h0000_0F00, "ctrl_unused_bits");
      wr(1, 1, 32'hABCD_1234);
      rd(1, 1, 32'h0000_1234, "preset_trunc");
      wr(0, 0, 32'h0);

      // Asynchronous reset with a pending interrupt
      wr(1, 1, 32'd2);
      wr(1, 0, 32'hB);
      idle(3);
      chk("pre_rst_any", 32'(IRQ_any), 32'h1);
      WE = 1'b0;
      Addr = {4'd1, 2'd1};
      #1 reset = 1'b1;
      #1;
      chk("arst_irq", 32'(IRQ), 32'h0);
      chk("arst_any", 32'(IRQ_any), 32'h0);
      chk("arst_dout", Dout, 32'h0);
      model_reset();
      @(posedge clk); #3;
      reset = 1'b0;
      rd(1, 0, 32'h0, "post_rst_ctrl");
      rd(1, 1, 32'h0, "post_rst_preset");
      rd(1, 2, 32'h0, "post_rst_count");
      rd(1, 3, 32'h0, "post_rst_status");

      // Random traffic against the model
      for (int k = 0; k < 4000; k++) begin
         int ch;
         int rg;
         bit we;
         logic [31:0] d;
         ch = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 15)) : int'($urandom_range(0, 1));
         rg = int'($urandom_range(0, 3));
         we = ($urandom_range(0, 4) == 0);
         d  = $urandom;
         if (rg == 0) begin
            d[11:8] = 4'($urandom_range(0, 3));
            d[0]    = ($urandom_range(0, 3) != 0);
            if (ch < N_CH && m_act[ch]) d[11:8] = 4'(m_psc[ch]);
         end else if (rg == 1) begin
            d[15:0] = 16'($urandom_range(0, 6));
         end
         cyc(we, ch, rg, d, 1'b0, '0, "");
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
